matrix_scan: RTL

- Display-side consumer of the 64-bit game frame produced by the drop action block.
- Latches a frame when data is flagged valid and drives an 8x8 LED matrix by row multiplexing, with blanking between rows.
- Paces the game: it pulses the action enable once every N displayed frames.
- Sits between the action block (matrix/d_act) and the top-level LED pins.

---
 rtl/matrix_scan_if.sv | 23 ++
 rtl/matrix_scan.sv | 122 ++++++++++++
 2 files changed

// File: rtl/matrix_scan_if.sv
// Link between the drop action block and the LED matrix scanner:
// frame data and its valid flag in, action enable and LED drive out.
interface matrix_scan_if #(
  parameter int gs = 8
);
  logic [gs*gs-1:0] matrix_i;
  logic             d_act_i;
  logic             e_act_o;
  logic [gs-1:0]    row_o;
  logic [gs-1:0]    col_o;
  logic             frame_start_o;

  // master = action-block side, slave = the scanner
  modport master (
    output matrix_i, d_act_i,
    input  e_act_o, row_o, col_o, frame_start_o
  );

  modport slave (
    input  matrix_i, d_act_i,
    output e_act_o, row_o, col_o, frame_start_o
  );
endinterface

// File: rtl/matrix_scan.sv
// Row-multiplexed 8x8 LED driver with inter-row blanking; latches a new frame
// only at frame end and paces the action block with a periodic enable pulse.
module matrix_scan #(
  parameter int gs             = 8,
  parameter int dwell          = 16,
  parameter int blank          = 2,
  parameter int frames_per_act = 4,
  parameter bit col_active_low = 1'b0
) (
  input  logic         clk_i,
  input  logic         reset_i,
  matrix_scan_if.slave bus
);

  localparam int cnt_max = (dwell > blank) ? dwell : blank;
  localparam int cnt_w   = (cnt_max > 1) ? $clog2(cnt_max) : 1;
  localparam int row_w   = (gs > 1) ? $clog2(gs) : 1;
  localparam int fc_w    = (frames_per_act > 1) ? $clog2(frames_per_act) : 1;
  localparam int idx_w   = (gs > 1) ? $clog2(gs*gs) : 1;

  localparam logic [0:0] st_blank = 1'b0;
  localparam logic [0:0] st_show  = 1'b1;
  // Entry state of every row; with no blanking the scan never leaves SHOW.
  localparam logic [0:0] st_row   = (blank == 0) ? st_show : st_blank;

  localparam logic [cnt_w-1:0] dwell_last = cnt_w'(dwell - 1);
  localparam logic [cnt_w-1:0] blank_last = cnt_w'((blank > 0) ? blank - 1 : 0);
  localparam logic [row_w-1:0] row_last   = row_w'(gs - 1);
  localparam logic [fc_w-1:0]  fc_last    = fc_w'(frames_per_act - 1);
  localparam logic [gs-1:0]    col_dark   = {gs{col_active_low}};

  logic [0:0]       state,     state_n;
  logic [cnt_w-1:0] cnt,       cnt_n;
  logic [row_w-1:0] row_idx,   row_n;
  logic [fc_w-1:0]  frame_cnt, fc_n;
  logic [gs*gs-1:0] frame_buf, buf_n;
  logic [gs-1:0]    row_q,     row_d;
  logic [gs-1:0]    col_q,     col_d;
  logic             e_act_q,   e_act_d;
  logic             fs_q;
  logic             frame_end;
  logic [idx_w-1:0] bit_idx;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; that is what keeps this block free of latches.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    row_n     = row_idx;
    frame_end = 1'b0;
    if (state == st_blank) begin
      if (cnt == blank_last) begin
        state_n = st_show;
        cnt_n   = '0;
      end
    end else if (cnt == dwell_last) begin
      state_n   = st_row;
      cnt_n     = '0;
      frame_end = (row_idx == row_last);
      row_n     = frame_end ? '0 : row_idx + 1'b1;
    end

    buf_n   = (frame_end && bus.d_act_i) ? bus.matrix_i : frame_buf;
    fc_n    = frame_cnt;
    e_act_d = 1'b0;
    if (frame_end) begin
      if (frame_cnt == fc_last) begin
        fc_n    = '0;
        e_act_d = 1'b1;
      end else begin
        fc_n = frame_cnt + 1'b1;
      end
    end

    // Outputs are decoded from the next state so the registered drive lines
    // up with the state it belongs to, using the freshly loaded buffer.
    row_d   = '0;
    col_d   = col_dark;
    bit_idx = '0;
    if (state_n == st_show) begin
      row_d[row_n] = 1'b1;
      for (int c = 0; c < gs; c++) begin
        bit_idx  = idx_w'(c * gs) + idx_w'(row_n);
        col_d[c] = buf_n[bit_idx] ^ col_active_low;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= st_row;
      cnt       <= '0;
      row_idx   <= '0;
      frame_cnt <= '0;
      // NOTE: the frame buffer is reset on purpose: the first frame after
      // reset must be dark, not whatever the flops powered up with.
      frame_buf <= '0;
      row_q     <= '0;
      col_q     <= col_dark;
      e_act_q   <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      row_idx   <= row_n;
      frame_cnt <= fc_n;
      frame_buf <= buf_n;
      row_q     <= row_d;
      col_q     <= col_d;
      e_act_q   <= e_act_d;
      fs_q      <= frame_end;
    end
  end

  assign bus.row_o         = row_q;
  assign bus.col_o         = col_q;
  assign bus.e_act_o       = e_act_q;
  assign bus.frame_start_o = fs_q;

endmodule
